// File: rtl/titan_spi_target.sv
// SPI mode-0 target front end: oversamples the SCK/CS/PICO pads in the system clock domain,
// turns PICO into a byte stream and shifts queued response bytes out on POCI.
module titan_spi_target #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       sys_clock_i,
  input  logic       sys_reset_i,
  input  logic       spi_clock_i,
  input  logic       spi_cs_i,
  input  logic       spi_pico_i,
  output logic       spi_poci_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       frame_active_o,
  output logic       frame_end_o,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // Pad synchronizers plus one history flop each for SCK and CS edge detection.
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] pico_sync_q;
  logic                   sck_hist_q;
  logic                   cs_hist_q;
  logic [SYNC_STAGES:0]   primed_q;

  logic sck_s, cs_s, pico_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic primed;

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      pico_sync_q <= '0;
      sck_hist_q  <= 1'b0;
      cs_hist_q   <= 1'b1;
      primed_q    <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clock_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], spi_pico_i};
      sck_hist_q  <= sck_s;
      cs_hist_q   <= cs_s;
      primed_q    <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign pico_s   = pico_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;
  // The CS chain comes out of reset reading "high"; that is not a real idle
  // observation until the pad value has propagated through every stage.
  assign primed   = primed_q[SYNC_STAGES];

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       underrun_q, underrun_d;
  logic       frame_end_q, frame_end_d;
  logic       poci_q, poci_d;
  logic       load;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_end_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (primed && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          load      = 1'b1;
          bit_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      ACTIVE: begin
        // CS release wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], pico_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], pico_s};
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            load       = 1'b1;
          end
        end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (load) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end

    // tx stream: a byte moves into the holding register on any cycle where
    // tx_valid_i and tx_ready_o are both high; tx_ready_o means "holding empty".
    // A load in the same cycle took the old (empty) content, so capture still wins.
    if (tx_valid_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data_i;
    end

    poci_d = (state_d == ACTIVE) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      poci_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      underrun_q  <= underrun_d;
      frame_end_q <= frame_end_d;
      poci_q      <= poci_d;
    end
  end

  assign spi_poci_o     = poci_q;
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_first_o     = rx_first_q;
  assign tx_ready_o     = ~hold_full_q;
  assign tx_underrun_o  = underrun_q;
  assign frame_active_o = (state_q == ACTIVE);
  assign frame_end_o    = frame_end_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_titan_spi_target.sv
// Bench for titan_spi_target: a mode-0 host driver at f_sys = 8 x f_sck and a
// byte-level reference model of the rx stream, response queue and pulse counts.
module tb_titan_spi_target;

  localparam int H = 4;  // sys clocks per SCK half period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_pico = 1'b0;
  logic       spi_poci_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_first_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       tx_underrun_o;
  logic       frame_active_o;
  logic       frame_end_o;
  logic [1:0] dbg_state;

  titan_spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .sys_clock_i(clk), .sys_reset_i(rst),
    .spi_clock_i(spi_sck), .spi_cs_i(spi_cs), .spi_pico_i(spi_pico), .spi_poci_o(spi_poci_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_first_o(rx_first_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_underrun_o(tx_underrun_o), .frame_active_o(frame_active_o), .frame_end_o(frame_end_o),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Counters and queues
  int vectors = 0;
  int miscompares = 0;
  int under_cnt = 0, fe_cnt = 0, fa_cnt = 0, rdy_cnt = 0;
  bit rdy_en = 1'b0;
  int exp_under = 0;

  logic [7:0] rx_got_q[$];
  logic       rxf_got_q[$];
  logic [7:0] exp_q[$];
  logic       expf_q[$];
  logic [7:0] pend_q[$];   // model of the response holding register

  logic [7:0] fr_tx[4];
  logic [7:0] fr_resp[4];
  bit         fr_offer[4];

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_got_q.push_back(rx_data_o);
      rxf_got_q.push_back(rx_first_o);
    end
    if (tx_underrun_o) under_cnt++;
    if (frame_end_o) fe_cnt++;
    if (frame_active_o) fa_cnt++;
    if (rdy_en && tx_ready_o) rdy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sys_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model of a shift-register load: next queued response byte, or IDLE_BYTE with an underrun.
  function automatic logic [7:0] take();
    if (pend_q.size() > 0) return pend_q.pop_front();
    exp_under++;
    return 8'hFF;
  endfunction

  task automatic offer_tx(input logic [7:0] b);
    logic r;
    int n;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    r = tx_ready_o;
    n = 0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = tx_ready_o;
      n++;
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
    check("tx_handshake", 32'(r), 32'd1);
    if (r) pend_q.push_back(b);
  endtask

  // Host shifts nbits MSB-first; POCI is sampled just before each rising edge.
  task automatic spi_byte(input logic [7:0] b, input int nbits, input bit cs_last,
                          output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_pico = b[7-i];
      sys_wait(H);
      got[7-i] = spi_poci_o;
      spi_sck = 1'b1;
      if (cs_last && i == nbits - 1) spi_cs = 1'b1;
      sys_wait(H);
      spi_sck = 1'b0;
    end
  endtask

  task automatic compare_rx();
    logic [7:0] e, g;
    logic ef, gf;
    check("rx_count", 32'(rx_got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ef = expf_q.pop_front();
      if (rx_got_q.size() > 0) begin
        g  = rx_got_q.pop_front();
        gf = rxf_got_q.pop_front();
        check("rx_data", 32'(g), 32'(e));
        check("rx_first", 32'(gf), 32'(ef));
      end
    end
    rx_got_q.delete();
    rxf_got_q.delete();
  endtask

  task automatic start_frame_counts();
    exp_under = 0; under_cnt = 0; fe_cnt = 0;
    rx_got_q.delete(); rxf_got_q.delete();
    exp_q.delete(); expf_q.delete();
  endtask

  // Full-byte frame described by fr_tx/fr_resp/fr_offer
  task automatic run_frame(input int n);
    logic [7:0] exp_p, got;
    start_frame_counts();
    if (fr_offer[0] && pend_q.size() == 0) offer_tx(fr_resp[0]);
    spi_cs = 1'b0;
    exp_p = take();
    sys_wait(H);
    check("frame_active_on", 32'(frame_active_o), 32'd1);
    check("underrun_at_cs_fall", 32'(under_cnt), 32'(exp_under));
    for (int k = 0; k < n; k++) begin
      if (k + 1 < n && fr_offer[k+1] && pend_q.size() == 0) offer_tx(fr_resp[k+1]);
      spi_byte(fr_tx[k], 8, 1'b0, got);
      check("poci_byte", 32'(got), 32'(exp_p));
      exp_q.push_back(fr_tx[k]);
      expf_q.push_back(k == 0);
      exp_p = take();
    end
    sys_wait(H);
    spi_cs = 1'b1;
    sys_wait(12);
    check("frame_active_off", 32'(frame_active_o), 32'd0);
    check("frame_end_count", 32'(fe_cnt), 32'd1);
    check("underrun_count", 32'(under_cnt), 32'(exp_under));
    compare_rx();
  endtask

  initial begin
    logic [7:0] got, exp_p;

    // Reset state
    rst = 1'b1;
    sys_wait(3);
    check("rst_poci", 32'(spi_poci_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("rst_rx_first", 32'(rx_first_o), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check("rst_underrun", 32'(tx_underrun_o), 32'd0);
    check("rst_frame_active", 32'(frame_active_o), 32'd0);
    check("rst_frame_end", 32'(frame_end_o), 32'd0);
    rst = 1'b0;
    sys_wait(10);

    // Two-byte frame with both responses queued ahead of their boundaries
    fr_tx[0] = 8'hA5; fr_tx[1] = 8'h3C;
    fr_resp[0] = 8'h5A; fr_resp[1] = 8'hC3;
    fr_offer[0] = 1'b1; fr_offer[1] = 1'b1;
    run_frame(2);
    sys_wait(4);

    // One byte with nothing queued: host sees IDLE_BYTE
    fr_tx[0] = 8'h00; fr_offer[0] = 1'b0;
    run_frame(1);
    sys_wait(4);

    // CS released after five rising edges: partial byte dropped
    start_frame_counts();
    spi_cs = 1'b0;
    exp_p = take();
    sys_wait(H);
    spi_byte(8'($urandom_range(0, 255)), 5, 1'b0, got);
    check("partial_poci", 32'(got[7:3]), 32'(exp_p[7:3]));
    sys_wait(H);
    spi_cs = 1'b1;
    sys_wait(12);
    check("partial_rx_count", 32'(rx_got_q.size()), 32'd0);
    check("partial_frame_end", 32'(fe_cnt), 32'd1);
    check("partial_frame_active", 32'(frame_active_o), 32'd0);
    fr_tx[0] = 8'h81; fr_offer[0] = 1'b0;
    run_frame(1);
    sys_wait(4);

    // tx_valid held high across a 3-byte frame: every load finds a byte
    start_frame_counts();
    tx_data_i = 8'h11;
    tx_valid_i = 1'b1;
    sys_wait(2);
    rdy_cnt = 0;
    rdy_en = 1'b1;
    spi_cs = 1'b0;
    sys_wait(H);
    for (int k = 0; k < 3; k++) begin
      fr_tx[k] = 8'($urandom_range(0, 255));
      spi_byte(fr_tx[k], 8, 1'b0, got);
      check("held_valid_poci", 32'(got), 32'h11);
      exp_q.push_back(fr_tx[k]);
      expf_q.push_back(k == 0);
    end
    sys_wait(H);
    spi_cs = 1'b1;
    sys_wait(12);
    rdy_en = 1'b0;
    tx_valid_i = 1'b0;
    check("held_valid_ready_cycles", 32'(rdy_cnt), 32'd4);
    check("held_valid_underrun", 32'(under_cnt), 32'd0);
    check("held_valid_frame_end", 32'(fe_cnt), 32'd1);
    compare_rx();
    pend_q.delete();
    pend_q.push_back(8'h11);
    sys_wait(4);

    // CS rises in the same sys cycle as the eighth SCK rising edge
    start_frame_counts();
    spi_cs = 1'b0;
    exp_p = take();
    sys_wait(H);
    spi_byte(8'($urandom_range(0, 255)), 8, 1'b1, got);
    check("race_poci", 32'(got[7:1]), 32'(exp_p[7:1]));
    sys_wait(12);
    check("race_rx_count", 32'(rx_got_q.size()), 32'd0);
    check("race_frame_end", 32'(fe_cnt), 32'd1);
    check("race_frame_active", 32'(frame_active_o), 32'd0);
    sys_wait(4);

    // Reset mid-byte with CS held low: the rest of that frame is ignored
    start_frame_counts();
    spi_cs = 1'b0;
    exp_p = take();
    sys_wait(H);
    spi_byte(8'($urandom_range(0, 255)), 3, 1'b0, got);
    rst = 1'b1;
    sys_wait(2);
    rst = 1'b0;
    pend_q.delete();
    rx_got_q.delete(); rxf_got_q.delete();
    fa_cnt = 0; fe_cnt = 0;
    spi_byte(8'($urandom_range(0, 255)), 8, 1'b0, got);
    check("post_reset_poci", 32'(got), 32'd0);
    sys_wait(H);
    check("post_reset_rx_count", 32'(rx_got_q.size()), 32'd0);
    check("post_reset_frame_active", 32'(fa_cnt), 32'd0);
    spi_cs = 1'b1;
    sys_wait(12);
    check("post_reset_frame_end", 32'(fe_cnt), 32'd0);
    fr_tx[0] = 8'h7E; fr_resp[0] = 8'($urandom_range(0, 255)); fr_offer[0] = 1'b1;
    run_frame(1);
    sys_wait(4);

    // Randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        fr_tx[k]    = 8'($urandom_range(0, 255));
        fr_resp[k]  = 8'($urandom_range(0, 255));
        fr_offer[k] = 1'($urandom_range(0, 1));
      end
      run_frame(n);
      sys_wait($urandom_range(3, 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
